mixcolumns_sequencer: RTL and testbench



---
 rtl/aes_pkg.sv | 21 ++
 rtl/mix_column_unit.sv | 30 +++
 rtl/mixcolumns_sequencer.sv | 94 +++++++++
 tb/tb_mixcolumns_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, constants and the GF(2^8) xtime helper.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [7:0] AES_POLY_LO = 8'h1b;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Multiply by x in GF(2^8); reduce only when the MSB shifts out.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_LO : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns on a single 32-bit column (a0 in the MSB byte).
module mix_column_unit
  import aes_pkg::*;
(
  input  col_t col_in,
  output col_t col_out
);

  logic [7:0] a0, a1, a2, a3;
  logic [7:0] x0, x1, x2, x3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Doubled bytes; 3a is formed as xtime(a) ^ a below.
  always_comb begin
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
  end

  assign col_out[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
  assign col_out[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
  assign col_out[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
  assign col_out[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;

endmodule

// File: rtl/mixcolumns_sequencer.sv
// Runs the four columns of an AES state through one shared MixColumns unit,
// one column per clock, with a per-block bypass for the final round.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Producers hold valid and data until that edge; ready may depend
// on the other side's signals. in_ready is combinational on out_ready so a
// finished block can retire and the next one load on the same edge.
module mixcolumns_sequencer
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_skip,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  fsm_t       fsm, fsm_nxt;
  state_t     st;
  logic [1:0] col;
  col_t       col_sel, col_mix;
  logic       accept;

  assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (fsm == DONE);
  assign busy      = (fsm != IDLE);
  assign out_state = st;

  // Select the column currently being mixed.
  always_comb begin
    col_sel = st[127:96];
    case (col)
      2'd0: col_sel = st[127:96];
      2'd1: col_sel = st[95:64];
      2'd2: col_sel = st[63:32];
      2'd3: col_sel = st[31:0];
      default: col_sel = st[127:96];
    endcase
  end

  mix_column_unit u_mix (
    .col_in  (col_sel),
    .col_out (col_mix)
  );

  // State register and column counter: load on accept, write back in RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= '0;
      col <= 2'd0;
    end else if (accept) begin
      st  <= in_state;
      col <= 2'd0;
    end else if (fsm == RUN) begin
      case (col)
        2'd0: st[127:96] <= col_mix;
        2'd1: st[95:64]  <= col_mix;
        2'd2: st[63:32]  <= col_mix;
        2'd3: st[31:0]   <= col_mix;
        default: st[127:96] <= col_mix;
      endcase
      col <= col + 2'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  // Next-state logic; a skipped block goes straight to DONE.
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE: if (in_valid) fsm_nxt = in_skip ? DONE : RUN;
      RUN:  if (col == 2'd3) fsm_nxt = DONE;
      DONE: begin
        if (out_ready) begin
          if (in_valid) fsm_nxt = in_skip ? DONE : RUN;
          else          fsm_nxt = IDLE;
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mixcolumns_sequencer.sv
// Self-checking bench for mixcolumns_sequencer: directed vectors, bypass,
// backpressure, back-to-back, mid-run reset and randomized traffic against a
// GF(2^8) matrix-multiply reference model.
module tb_mixcolumns_sequencer;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_skip;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  bit  rnd_ready = 0;

  logic [127:0] exp_q[$];
  int           ret_cyc[$];

  mixcolumns_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_skip   (in_skip),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- reference model ----------------
  // Generic GF(2^8) multiply by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // Full-state MixColumns as a circulant matrix product, or identity on skip.
  function automatic logic [127:0] mix_ref(input logic [127:0] s, input bit skip);
    logic [7:0]   base[4];
    logic [7:0]   a[4];
    logic [7:0]   r;
    logic [127:0] res;
    base[0] = 8'd2; base[1] = 8'd3; base[2] = 8'd1; base[3] = 8'd1;
    if (skip) return s;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
      for (int i = 0; i < 4; i++) begin
        r = 8'h00;
        for (int j = 0; j < 4; j++) r = r ^ gmul(base[(j - i) & 3], a[j]);
        res[127 - 32*c - 8*i -: 8] = r;
      end
    end
    return res;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // A retirement happens on the next rising edge when both are high here.
  initial forever begin
    @(negedge clk);
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_out", 1'b1, 1'b0);
      else                   check("out_state", out_state, exp_q.pop_front());
      ret_cyc.push_back(cyc);
    end
  end

  // Random backpressure when enabled.
  initial forever begin
    @(posedge clk);
    #1;
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- driver tasks ----------------
  // Presents a block and returns 1ns after the accepting edge.
  task automatic send_block(input logic [127:0] s, input bit skip, input logic [127:0] e);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_state = s;
    in_skip  = skip;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      check("accept_timeout", 1'b0, 1'b1);
      in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_skip  = 1'b0;
    end
  endtask

  // Counts edges after the accepting edge until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [127:0] a_st, b_st, a_exp;

    rst_n = 1'b0; in_valid = 1'b0; in_state = '0; in_skip = 1'b0; out_ready = 1'b1;

    // Reset values while reset is held across an edge.
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out_state", out_state, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector 1, latency 4.
    send_block(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0,
               128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    wait_valid(lat);
    check("lat_normal", lat, 4);
    @(posedge clk); #1;

    // Directed vector 2: bytes with MSB set exercise reduction.
    send_block(128'hd4d4d4d5_2d26314c_00000000_00000000, 1'b0,
               128'hd5d5d7d6_4d7ebdf8_00000000_00000000);
    wait_valid(lat);
    check("lat_msb", lat, 4);
    @(posedge clk); #1;

    // Bypass: out_valid already high right after the accepting edge.
    a_st = rand128();
    send_block(a_st, 1'b1, a_st);
    check("skip_valid_next", out_valid, 1'b1);
    @(posedge clk); #1;

    // Backpressure for 7 cycles with a new block waiting.
    out_ready = 1'b0;
    a_st  = rand128();
    a_exp = mix_ref(a_st, 1'b0);
    b_st  = rand128();
    send_block(a_st, 1'b0, a_exp);
    wait_valid(lat);
    check("lat_bp", lat, 4);
    in_valid = 1'b1; in_state = b_st; in_skip = 1'b0;
    for (int i = 0; i < 7; i++) begin
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_out_state", out_state, a_exp);
      @(posedge clk); #1;
      in_state = (i == 3) ? rand128() : b_st;
      in_state = b_st;
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1'b1);
    exp_q.push_back(mix_ref(b_st, 1'b0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("same_edge_busy", busy, 1'b1);
    check("same_edge_valid", out_valid, 1'b0);
    wait_valid(lat);
    check("lat_after_bp", lat, 4);
    @(posedge clk); #1;

    // Back-to-back blocks retire 5 cycles apart.
    ret_cyc.delete();
    a_st = rand128();
    b_st = rand128();
    send_block(a_st, 1'b0, mix_ref(a_st, 1'b0));
    send_block(b_st, 1'b0, mix_ref(b_st, 1'b0));
    for (int n = 0; n < 40 && ret_cyc.size() < 2; n++) @(posedge clk);
    #1;
    if (ret_cyc.size() < 2) check("b2b_timeout", ret_cyc.size(), 2);
    else                    check("b2b_spacing", ret_cyc[1] - ret_cyc[0], 5);

    // Reset during RUN at col=2 aborts the block.
    a_st = rand128();
    send_block(a_st, 1'b0, mix_ref(a_st, 1'b0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_out_state", out_state, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("abort_no_output", out_valid, 1'b0);
    end
    send_block(128'hd4d4d4d5_2d26314c_00000000_00000000, 1'b0,
               128'hd5d5d7d6_4d7ebdf8_00000000_00000000);
    wait_valid(lat);
    check("lat_post_reset", lat, 4);
    @(posedge clk); #1;

    // Randomized traffic with random skip and random backpressure.
    rnd_ready = 1;
    for (int k = 0; k < 24; k++) begin
      bit sk;
      sk   = ($urandom_range(0, 3) == 0);
      a_st = rand128();
      send_block(a_st, sk, mix_ref(a_st, sk));
    end
    for (int n = 0; n < 400 && exp_q.size() > 0; n++) begin
      @(posedge clk); #1;
    end
    check("drain", exp_q.size(), 0);
    rnd_ready = 0;
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
